// File: rtl/display_frame_sequencer.sv
// Frame sequencer for the ILI9341 8080 path: emits the CASET/PASET/RAMWR window
// preamble, then splits RGB565 pixels into hi/lo data bytes, policing frame length.
module display_frame_sequencer #(
  parameter int X_RES = 320,
  parameter int Y_RES = 240
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        enable,
  input  logic [8:0]  cfg_x0,
  input  logic [8:0]  cfg_x1,
  input  logic [8:0]  cfg_y0,
  input  logic [8:0]  cfg_y1,
  input  logic        cfg_wr,
  output logic        cfg_err,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic [15:0] s_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [8:0]  m_axis_tdata,
  output logic        frame_done,
  output logic        len_err,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CMD    = 3'd1,
    PIX_HI = 3'd2,
    PIX_LO = 3'd3,
    FLUSH  = 3'd4
  } state_t;

  localparam logic [8:0] X_MAX = 9'(X_RES - 1);
  localparam logic [8:0] Y_MAX = 9'(Y_RES - 1);

  state_t      r_state, w_next;
  logic [8:0]  r_x0, r_x1, r_y0, r_y1;
  logic [8:0]  r_px0, r_px1, r_py0, r_py1;
  logic        r_pend_vld;
  logic [3:0]  r_cmd_idx;
  logic [16:0] r_n, r_cnt;
  logic        r_cfg_err, r_frame_done, r_len_err;

  logic        w_cfg_ok, w_start, w_consume, w_last_pix, w_done, w_len_err;
  logic [9:0]  w_w, w_h;
  logic [16:0] w_n;
  logic [8:0]  w_cmd_byte;

  assign w_cfg_ok   = (cfg_x0 <= cfg_x1) && (cfg_x1 <= X_MAX) &&
                      (cfg_y0 <= cfg_y1) && (cfg_y1 <= Y_MAX);
  assign w_start    = (r_state == IDLE) && enable && s_axis_tvalid;
  assign w_consume  = (r_state == PIX_LO) && s_axis_tvalid && m_axis_tready;
  assign w_last_pix = (r_cnt + 17'd1) == r_n;
  assign w_w        = ({1'b0, r_x1} - {1'b0, r_x0}) + 10'd1;
  assign w_h        = ({1'b0, r_y1} - {1'b0, r_y0}) + 10'd1;
  assign w_n        = 17'(w_w) * 17'(w_h);

  // Preamble byte: {dc, byte}; coordinate high bytes carry only bit 8.
  always_comb begin
    w_cmd_byte = 9'h000;
    case (r_cmd_idx)
      4'd0:    w_cmd_byte = {1'b0, 8'h2A};
      4'd1:    w_cmd_byte = {1'b1, 7'd0, r_x0[8]};
      4'd2:    w_cmd_byte = {1'b1, r_x0[7:0]};
      4'd3:    w_cmd_byte = {1'b1, 7'd0, r_x1[8]};
      4'd4:    w_cmd_byte = {1'b1, r_x1[7:0]};
      4'd5:    w_cmd_byte = {1'b0, 8'h2B};
      4'd6:    w_cmd_byte = {1'b1, 7'd0, r_y0[8]};
      4'd7:    w_cmd_byte = {1'b1, r_y0[7:0]};
      4'd8:    w_cmd_byte = {1'b1, 7'd0, r_y1[8]};
      4'd9:    w_cmd_byte = {1'b1, r_y1[7:0]};
      default: w_cmd_byte = {1'b0, 8'h2C};
    endcase
  end

  // Both streams: a beat transfers on a rising edge where valid && ready; a
  // valid beat is held unchanged until it transfers. The input pixel is only
  // consumed on the low-byte transfer.
  always_comb begin
    w_next        = r_state;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = 9'h000;
    m_axis_tlast  = 1'b0;
    s_axis_tready = 1'b0;
    w_done        = 1'b0;
    w_len_err     = 1'b0;
    case (r_state)
      IDLE: if (w_start) w_next = CMD;
      CMD: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = w_cmd_byte;
        if (m_axis_tready && r_cmd_idx == 4'd10) w_next = PIX_HI;
      end
      PIX_HI: begin
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = {1'b1, s_axis_tdata[15:8]};
        if (s_axis_tvalid && m_axis_tready) w_next = PIX_LO;
      end
      PIX_LO: begin
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = {1'b1, s_axis_tdata[7:0]};
        s_axis_tready = m_axis_tready;
        if (w_consume) begin
          if (w_last_pix || s_axis_tlast) begin
            m_axis_tlast = 1'b1;
            w_done       = 1'b1;
            w_len_err    = w_last_pix != s_axis_tlast;
            w_next       = (w_last_pix && !s_axis_tlast) ? FLUSH : IDLE;
          end else begin
            w_next = PIX_HI;
          end
        end
      end
      FLUSH: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid && s_axis_tlast) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_x0 <= 9'd0;  r_x1 <= X_MAX;  r_y0 <= 9'd0;  r_y1 <= Y_MAX;
      r_px0 <= 9'd0; r_px1 <= 9'd0;  r_py0 <= 9'd0; r_py1 <= 9'd0;
      r_pend_vld   <= 1'b0;
      r_cmd_idx    <= 4'd0;
      r_n          <= 17'd0;
      r_cnt        <= 17'd0;
      r_cfg_err    <= 1'b0;
      r_frame_done <= 1'b0;
      r_len_err    <= 1'b0;
    end else begin
      // The window only moves at frame start, so a frame never sees a mix.
      if (w_start) begin
        if (r_pend_vld) begin
          r_x0 <= r_px0; r_x1 <= r_px1; r_y0 <= r_py0; r_y1 <= r_py1;
        end
        r_pend_vld <= 1'b0;
        r_cmd_idx  <= 4'd0;
        r_cnt      <= 17'd0;
      end
      if (cfg_wr && w_cfg_ok) begin
        r_px0 <= cfg_x0; r_px1 <= cfg_x1; r_py0 <= cfg_y0; r_py1 <= cfg_y1;
        r_pend_vld <= 1'b1;
      end
      if (r_state == CMD) begin
        r_n <= w_n;
        if (m_axis_tready) r_cmd_idx <= r_cmd_idx + 4'd1;
      end
      if (w_consume) r_cnt <= r_cnt + 17'd1;
      r_cfg_err    <= cfg_wr && !w_cfg_ok;
      r_frame_done <= w_done;
      r_len_err    <= w_len_err;
    end
  end

  assign cfg_err    = r_cfg_err;
  assign frame_done = r_frame_done;
  assign len_err    = r_len_err;
  assign dbg_state  = r_state;

endmodule
